term_packer: RTL and testbench
==============================

// Module: term_packer
// PURPOSE
//  Serial-to-parallel producer for the pipelined tree adder input bus. It accepts one
//  WORD_WIDTH word per valid/ready handshake and packs NUM_TERMS consecutive words into
//  one WORD_WIDTH*NUM_TERMS vector. It presents that vector on a valid/ready output.
//  It sits between the serial product/operand stream and the parallel reduction stage
//  of the Conv2D 3x3 datapath.
// PARAMETERS
//  WORD_WIDTH  8  bits per term; must be >= 1 (elaboration $error otherwise)
//  NUM_TERMS   9  terms per packed group; must be >= 2 (elaboration $error otherwise)
// PORTS
//  i_clk      in   1                     single clock, all state on rising edge
//  i_rst_n    in   1                     asynchronous active-low reset
//  i_word     in   WORD_WIDTH            input term
//  i_valid    in   1                     i_word valid
//  o_ready    out  1                     packer can accept i_word this cycle
//  o_terms    out  WORD_WIDTH*NUM_TERMS  packed group; slot k = o_terms[WORD_WIDTH*k +: WORD_WIDTH]
//  o_valid    out  1                     o_terms holds a complete group
//  i_ready    in   1                     downstream accepts o_terms this cycle
//  o_fill     out  $clog2(NUM_TERMS+1)   words currently held in the filling group
// BEHAVIOUR
//  - Reset (async assert, sync release): o_valid=0, o_terms=0, o_fill=0, write slot=0.
//    Output o_ready=1 while in reset. Reset mid-group discards the partial group.
//    Reset during o_valid drops the held group; no partial output is ever emitted.
//  - Input accept: i_valid & o_ready. Output accept: o_valid & i_ready.
//  - o_ready = !o_valid | i_ready. This is a combinational path from i_ready.
//  - Word acceptance:
//    - The first accepted word of a group goes to slot 0, the next to slot 1, and so on.
//    - The write slot counter runs 0..NUM_TERMS-1 and wraps to 0 after the last slot.
//  - States:
//    - FILL (o_valid=0): each accept writes slot[cnt] and increments cnt.
//      Accepting slot NUM_TERMS-1 asserts o_valid on the next cycle (HOLD), with cnt=0.
//    - HOLD (o_valid=1): o_terms is frozen while !i_ready; o_ready=0, so no input is taken.
//  - HOLD with i_ready=1 and an input accept in the same cycle (simultaneous events):
//    - The group retires and the new word is written to slot 0; next cycle is FILL, cnt=1.
//    - Slots 1..NUM_TERMS-1 keep stale data; they are overwritten before the next o_valid.
//  - HOLD with i_ready=1 and no input: the group retires, next cycle FILL with cnt=0.
//  - Throughput: one word per cycle sustained, no bubble between groups.
//  - Latency: o_valid rises 1 cycle after the accept of the last word.
//  - o_fill = number of valid slots in the filling group. It equals 0 in HOLD unless
//    the simultaneous case above applies.
//  - Input protocol is the same as the output protocol: i_word and i_valid are held by
//    the source until accepted; o_terms and o_valid are held stable until i_ready.
// CONFIGURATION
//  Macro TERM_PACKER_LAST_EN:
//  - Defined: adds input port i_last (1 bit, qualifies i_word).
//    - An accepted word with i_last=1 closes the group early.
//    - All slots above that word are zero-filled, so a partial group reduces to the
//      correct sum downstream, and the group enters HOLD the next cycle.
//    - i_last on slot NUM_TERMS-1 behaves as a normal full group.
//  - Undefined: no i_last port; groups are closed only by the count.
// STRUCTURE
//  - Shared package conv_pkg:
//    - WORD_WIDTH default constant.
//    - ceil_log2 function used for the o_fill width.
//    - typedef enum logic {FILL, HOLD} packer_state_t.
//  - No sub-module: the slot counter, the slot register array and the state flop are inline.
//  - Each slot register is written with a one-hot enable decoded from cnt.
// TESTING  (WORD_WIDTH=8, NUM_TERMS=3 unless noted)
//  1. Reset, then stream 0x01,0x02,0x03 with i_ready=1.
//     -> o_valid for exactly 1 cycle, o_terms=0x030201, o_fill 0,1,2,0.
//  2. Fill 0x0A,0x0B,0x0C with i_ready=0 for 5 cycles.
//     -> o_terms stable at 0x0C0B0A, o_ready=0, no word accepted, then 1 cycle to retire.
//  3. Continuous i_valid=1 with 0x10..0x18 and i_ready=1.
//     -> groups 0x121110, 0x151413, 0x181716 on consecutive every-3rd cycles, o_ready never low.
//  4. Assert i_rst_n=0 after 2 words (0x21,0x22), then send 0x31,0x32,0x33.
//     -> first group out is 0x333231; nothing containing 0x21 appears.
//  5. TERM_PACKER_LAST_EN defined: send 0x05, then 0x06 with i_last=1.
//     -> o_terms=0x000605, o_valid next cycle, the following group starts at slot 0.
//  6. NUM_TERMS=9, random i_valid/i_ready (50%).
//     -> scoreboard: every output group equals 9 consecutive accepted words in order,
//        with no loss and no duplication.

Source files
------------

// File: rtl/term_packer_pkg.sv
// conv_pkg: shared Conv2D datapath types and helpers for the term packer.
package conv_pkg;
    localparam int DEF_WORD_WIDTH = 8;
    typedef enum logic {FILL, HOLD} packer_state_t;
    function automatic int ceil_log2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
        return r;
    endfunction
endpackage

// File: rtl/term_packer_if.sv
// term_packer_if: serial word input and packed group output of the term packer.
// TERM_PACKER_LAST_EN adds i_last to close a group early.
interface term_packer_if
    import conv_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_TERMS  = 9
) ();
    localparam int FW = ceil_log2(NUM_TERMS + 1);
    logic [WORD_WIDTH-1:0]           i_word;
    logic                            i_valid;
    logic                            o_ready;
    logic [WORD_WIDTH*NUM_TERMS-1:0] o_terms;
    logic                            o_valid;
    logic                            i_ready;
    logic [FW-1:0]                   o_fill;
`ifdef TERM_PACKER_LAST_EN
    logic                            i_last;
`endif
    modport slave (
`ifdef TERM_PACKER_LAST_EN
        input i_last,
`endif
        input i_word, i_valid, i_ready,
        output o_ready, o_terms, o_valid, o_fill
    );
    modport master (
`ifdef TERM_PACKER_LAST_EN
        output i_last,
`endif
        output i_word, i_valid, i_ready,
        input o_ready, o_terms, o_valid, o_fill
    );
endinterface

// File: rtl/term_packer.sv
// term_packer: packs NUM_TERMS serial words into one parallel group with valid/ready.
// TERM_PACKER_LAST_EN: i_last closes a group early, zero-filling the upper slots.
module term_packer
    import conv_pkg::*;
#(
    parameter int WORD_WIDTH = DEF_WORD_WIDTH,
    parameter int NUM_TERMS  = 9
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    term_packer_if.slave  bus
);
    localparam int FW = ceil_log2(NUM_TERMS + 1);
    if (WORD_WIDTH < 1) begin : g_bad_width
        $error("term_packer: WORD_WIDTH must be >= 1");
    end
    if (NUM_TERMS < 2) begin : g_bad_terms
        $error("term_packer: NUM_TERMS must be >= 2");
    end
    packer_state_t r_state, w_state;
    logic [FW-1:0] r_cnt, w_cnt;
    logic w_in_acc, w_last, w_close;
    assign bus.o_valid = r_state == HOLD;
    assign bus.o_ready = !bus.o_valid | bus.i_ready;
    assign bus.o_fill  = r_cnt;
    assign w_in_acc    = bus.i_valid & bus.o_ready;
`ifdef TERM_PACKER_LAST_EN
    assign w_last = bus.i_last;
`else
    assign w_last = 1'b0;
`endif
    assign w_close = w_in_acc & (w_last | (r_cnt == FW'(NUM_TERMS - 1)));
    // An accept in HOLD implies i_ready, so the held group retires in the same cycle.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        if (w_in_acc) begin
            w_state = w_close ? HOLD : FILL;
            w_cnt   = w_close ? '0 : r_cnt + 1'b1;
        end else if (bus.o_valid & bus.i_ready) begin
            w_state = FILL;
            w_cnt   = '0;
        end
    end
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= FILL;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
        end
    end
    for (genvar k = 0; k < NUM_TERMS; k++) begin : g_slot
        logic [WORD_WIDTH-1:0] r_slot;
        logic w_wen, w_zero;
        assign w_wen  = w_in_acc & (r_cnt == FW'(k));
        assign w_zero = w_in_acc & w_last & (r_cnt < FW'(k));
        always_ff @(posedge i_clk or negedge i_rst_n) begin
            if (!i_rst_n) r_slot <= '0;
            else if (w_wen) r_slot <= bus.i_word;
            else if (w_zero) r_slot <= '0;
        end
        assign bus.o_terms[WORD_WIDTH*k +: WORD_WIDTH] = r_slot;
    end
endmodule

// File: tb/tb_term_packer.sv
// tb_term_packer: directed vector table on a 3-term packer plus a random scoreboard on a 9-term packer.
module tb_term_packer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int failures = 0;
    always #5 clk = ~clk;

    term_packer_if #(.WORD_WIDTH(8), .NUM_TERMS(3)) b3 ();
    term_packer_if #(.WORD_WIDTH(8), .NUM_TERMS(9)) b9 ();
    term_packer #(.WORD_WIDTH(8), .NUM_TERMS(3)) u3 (.i_clk(clk), .i_rst_n(rst_n), .bus(b3.slave));
    term_packer #(.WORD_WIDTH(8), .NUM_TERMS(9)) u9 (.i_clk(clk), .i_rst_n(rst_n), .bus(b9.slave));

    typedef struct {
        logic        v;
        logic [7:0]  w;
        logic        r;
        logic        er;
        logic        ev;
        logic [23:0] et;
        logic [1:0]  ef;
    } vec_t;
    vec_t tbl[26];

    task automatic chk(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drv(input logic v, input logic [7:0] w, input logic r, input logic l);
        @(negedge clk);
        b3.i_valid = v;
        b3.i_word  = w;
        b3.i_ready = r;
`ifdef TERM_PACKER_LAST_EN
        b3.i_last  = l;
`else
        if (l) $display("note: i_last ignored in this build");
`endif
        #1;
    endtask

    task automatic chk3(input string n, input logic er, input logic ev, input logic [23:0] et, input logic [1:0] ef);
        chk({n, "_ready"}, b3.o_ready, er);
        chk({n, "_valid"}, b3.o_valid, ev);
        chk({n, "_terms"}, b3.o_terms, et);
        chk({n, "_fill"},  b3.o_fill,  ef);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [71:0] exp9;
        int sent, groups;
        logic acc;
        b3.i_valid = 0; b3.i_word = 0; b3.i_ready = 0;
        b9.i_valid = 0; b9.i_word = 0; b9.i_ready = 0;
`ifdef TERM_PACKER_LAST_EN
        b3.i_last = 0; b9.i_last = 0;
`endif
        tbl[0]  = '{1'b1, 8'h01, 1'b1, 1'b1, 1'b0, 24'h000000, 2'd0};
        tbl[1]  = '{1'b1, 8'h02, 1'b1, 1'b1, 1'b0, 24'h000001, 2'd1};
        tbl[2]  = '{1'b1, 8'h03, 1'b1, 1'b1, 1'b0, 24'h000201, 2'd2};
        tbl[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h030201, 2'd0};
        tbl[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'h030201, 2'd0};
        tbl[5]  = '{1'b1, 8'h0A, 1'b0, 1'b1, 1'b0, 24'h030201, 2'd0};
        tbl[6]  = '{1'b1, 8'h0B, 1'b0, 1'b1, 1'b0, 24'h03020A, 2'd1};
        tbl[7]  = '{1'b1, 8'h0C, 1'b0, 1'b1, 1'b0, 24'h030B0A, 2'd2};
        for (int i = 8; i < 13; i++) tbl[i] = '{1'b1, 8'h0D, 1'b0, 1'b0, 1'b1, 24'h0C0B0A, 2'd0};
        tbl[13] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h0C0B0A, 2'd0};
        tbl[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'h0C0B0A, 2'd0};
        tbl[15] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 24'h0C0B0A, 2'd0};
        tbl[16] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 24'h0C0B10, 2'd1};
        tbl[17] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 24'h0C1110, 2'd2};
        tbl[18] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 24'h121110, 2'd0};
        tbl[19] = '{1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 24'h121113, 2'd1};
        tbl[20] = '{1'b1, 8'h15, 1'b1, 1'b1, 1'b0, 24'h121413, 2'd2};
        tbl[21] = '{1'b1, 8'h16, 1'b1, 1'b1, 1'b1, 24'h151413, 2'd0};
        tbl[22] = '{1'b1, 8'h17, 1'b1, 1'b1, 1'b0, 24'h151416, 2'd1};
        tbl[23] = '{1'b1, 8'h18, 1'b1, 1'b1, 1'b0, 24'h151716, 2'd2};
        tbl[24] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 24'h181716, 2'd0};
        tbl[25] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 24'h181716, 2'd0};

        repeat (2) @(negedge clk);
        #1;
        chk3("reset", 1'b1, 1'b0, 24'h0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 26; i++) begin
            drv(tbl[i].v, tbl[i].w, tbl[i].r, 1'b0);
            chk3($sformatf("vec%0d", i), tbl[i].er, tbl[i].ev, tbl[i].et, tbl[i].ef);
        end

        drv(1'b1, 8'h21, 1'b1, 1'b0);
        drv(1'b1, 8'h22, 1'b1, 1'b0);
        @(negedge clk);
        b3.i_valid = 1'b0;
        b3.i_ready = 1'b0;
        rst_n = 1'b0;
        #1;
        chk3("midreset", 1'b1, 1'b0, 24'h0, 2'd0);
        @(negedge clk);
        rst_n = 1'b1;
        drv(1'b1, 8'h31, 1'b1, 1'b0);
        chk3("rst_w31", 1'b1, 1'b0, 24'h000000, 2'd0);
        drv(1'b1, 8'h32, 1'b1, 1'b0);
        chk3("rst_w32", 1'b1, 1'b0, 24'h000031, 2'd1);
        drv(1'b1, 8'h33, 1'b1, 1'b0);
        chk3("rst_w33", 1'b1, 1'b0, 24'h003231, 2'd2);
        drv(1'b0, 8'h00, 1'b1, 1'b0);
        chk3("rst_grp", 1'b1, 1'b1, 24'h333231, 2'd0);
        drv(1'b0, 8'h00, 1'b1, 1'b0);
        chk3("rst_done", 1'b1, 1'b0, 24'h333231, 2'd0);

`ifdef TERM_PACKER_LAST_EN
        drv(1'b1, 8'h05, 1'b1, 1'b0);
        drv(1'b1, 8'h06, 1'b1, 1'b1);
        chk3("last_w06", 1'b1, 1'b0, 24'h333205, 2'd1);
        drv(1'b1, 8'h07, 1'b1, 1'b0);
        chk3("last_grp", 1'b1, 1'b1, 24'h000605, 2'd0);
        drv(1'b0, 8'h00, 1'b1, 1'b0);
        chk3("last_next", 1'b1, 1'b0, 24'h000607, 2'd1);
`endif

        sent = 0;
        groups = 0;
        acc = 1'b0;
        for (int c = 0; c < 4000 && groups < 20; c++) begin
            @(negedge clk);
            if (acc) b9.i_valid = 1'b0;
            acc = 1'b0;
            if (!b9.i_valid && $urandom_range(1) == 1) begin
                b9.i_valid = 1'b1;
                b9.i_word  = 8'(sent);
                sent++;
            end
            b9.i_ready = 1'($urandom_range(1));
            #1;
            if (b9.o_valid && b9.i_ready) begin
                if (q.size() < 9) begin
                    chk("n9_underflow", 72'(q.size()), 72'd9);
                end else begin
                    for (int k = 0; k < 9; k++) exp9[8*k +: 8] = q.pop_front();
                    chk($sformatf("n9_group%0d", groups), b9.o_terms, exp9);
                end
                groups++;
            end
            if (b9.i_valid && b9.o_ready) begin
                q.push_back(b9.i_word);
                acc = 1'b1;
            end
        end
        chk("n9_group_count", 72'(groups >= 20), 72'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
